fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined MIPS core; successor to the fixed two-stage store-data forwarding logic. It keeps a shift-register scoreboard of in-flight register writes over DEPTH downstream stages. It resolves NUM_SRC source operands of the issuing instruction against that scoreboard, picking the youngest producer. It emits per-source forward selects and muxed data, and raises a load-use stall when the youngest producer's result is not yet available.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_resolve.sv | 44 ++++
 rtl/fwd_scoreboard.sv | 96 +++++++++
 tb/tb_fwd_scoreboard.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Destination fields are stored at MAX_REG_AW bits so the package needs no parameters.
package fwd_pkg;

    localparam int unsigned MAX_REG_AW = 8;
    localparam int unsigned FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  vld;
        logic                  we;
        logic                  load;
        logic [MAX_REG_AW-1:0] dst;
    } fwd_entry_t;

    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_resolve.sv
// Per-source priority resolver: the youngest matching in-flight write wins.
// A winner that is a load still short of LOAD_RDY reports not_ready instead of forwarding.
module fwd_resolve
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_RDY = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  fwd_entry_t [DEPTH-1:0]  entries,
    input  logic [REG_AW-1:0]       src,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       data,
    output logic                    not_ready
);

    logic [MAX_REG_AW-1:0] src_ext;
    logic                  found;

    assign src_ext = MAX_REG_AW'(src);

    always_comb begin
        sel       = SEL_W'(FWD_SEL_RF);
        data      = '0;
        not_ready = 1'b0;
        found     = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && entries[i].vld && entries[i].we &&
                entries[i].dst != '0 && entries[i].dst == src_ext) begin
                found = 1'b1;
                if (!entries[i].load || i >= LOAD_RDY) begin
                    sel  = SEL_W'(i + 1);
                    data = stage_data[i*DATA_W +: DATA_W];
                end else begin
                    not_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shift-register scoreboard of in-flight writes plus per-source resolvers.
// Optional macro FWD_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_RDY = 1,
    localparam int unsigned SEL_W   = sel_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_we,
    input  logic                      issue_is_load,
    input  logic [REG_AW-1:0]         issue_dst,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data,
    output logic                      stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    fwd_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [NUM_SRC-1:0]     not_ready;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_resolve #(
            .REG_AW  (REG_AW),
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .LOAD_RDY(LOAD_RDY),
            .SEL_W   (SEL_W)
        ) u_resolve (
            .entries   (entries_q),
            .src       (src_addr[k*REG_AW +: REG_AW]),
            .stage_data(stage_data),
            .sel       (fwd_sel[k*SEL_W +: SEL_W]),
            .data      (fwd_data[k*DATA_W +: DATA_W]),
            .not_ready (not_ready[k])
        );
    end

    assign stall = issue_valid && (|not_ready);

    // Older entries always advance; a stalled issue inserts a bubble at entry 0.
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].vld = 1'b0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = '0;
            if (issue_valid && !stall) begin
                entries_d[0].vld  = 1'b1;
                entries_d[0].we   = issue_we;
                entries_d[0].load = issue_is_load;
                entries_d[0].dst  = MAX_REG_AW'(issue_dst);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed table-driven bench for fwd_scoreboard (DEPTH=3, LOAD_RDY=1, NUM_SRC=2).
// Counter checks are compiled in only when FWD_STALL_CNT_EN is defined.
module tb_fwd_scoreboard;

    localparam int NV = 20;
    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'h3333_3333;

    typedef struct {
        logic        v, we, ld, fl;
        logic [4:0]  dst, s0, s1;
        logic [31:0] sd0, sd1, sd2;
        logic [1:0]  es0, es1;
        logic        est;
        logic [31:0] ed0, ed1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        issue_valid, issue_we, issue_is_load;
    logic [4:0]  issue_dst;
    logic [9:0]  src_addr;
    logic [95:0] stage_data;
    logic [3:0]  fwd_sel;
    logic [63:0] fwd_data;
    logic        stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [NV];

    fwd_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_is_load(issue_is_load),
        .issue_dst    (issue_dst),
        .src_addr     (src_addr),
        .stage_data   (stage_data),
        .fwd_sel      (fwd_sel),
        .fwd_data     (fwd_data),
        .stall        (stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, we, ld, fl, input logic [4:0] dst, s0, s1,
                                input logic [31:0] sd0, sd1, sd2, input logic [1:0] es0, es1,
                                input logic est, input logic [31:0] ed0, ed1);
        vec_t r;
        r.v = v; r.we = we; r.ld = ld; r.fl = fl;
        r.dst = dst; r.s0 = s0; r.s1 = s1;
        r.sd0 = sd0; r.sd1 = sd1; r.sd2 = sd2;
        r.es0 = es0; r.es1 = es1; r.est = est; r.ed0 = ed0; r.ed1 = ed1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        issue_valid   = t.v;
        issue_we      = t.we;
        issue_is_load = t.ld;
        flush         = t.fl;
        issue_dst     = t.dst;
        src_addr      = {t.s1, t.s0};
        stage_data    = {t.sd2, t.sd1, t.sd0};
    endtask

    // Drive one cycle's inputs, compare the combinational outputs, then take the clock edge.
    task automatic apply(input string tag, input vec_t t);
        drive(t);
        #3;
        check({tag, " sel0"}, 32'(fwd_sel[1:0]), 32'(t.es0));
        check({tag, " sel1"}, 32'(fwd_sel[3:2]), 32'(t.es1));
        check({tag, " data0"}, fwd_data[31:0], t.ed0);
        check({tag, " data1"}, fwd_data[63:32], t.ed1);
        check({tag, " stall"}, 32'(stall), 32'(t.est));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                v  we ld fl dst s0  s1  sd0    sd1    sd2  es0 es1 st ed0    ed1
        vecs[0]  = mk(0, 0, 0, 0, 0,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[1]  = mk(1, 1, 0, 0, 5,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[2]  = mk(1, 0, 0, 0, 0,  5,  0,  D0,    D1,    D2,  1,  0,  0, D0,    0);
        vecs[3]  = mk(1, 1, 1, 0, 9,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[4]  = mk(1, 1, 0, 0, 10, 0,  9,  D0,    D1,    D2,  0,  0,  1, 0,     0);
        vecs[5]  = mk(1, 1, 0, 0, 10, 10, 9,  D0,    D1,    D2,  0,  2,  0, 0,     D1);
        vecs[6]  = mk(1, 1, 0, 0, 3,  10, 9,  D0,    D1,    D2,  1,  3,  0, D0,    D2);
        vecs[7]  = mk(1, 1, 0, 0, 3,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[8]  = mk(1, 1, 0, 0, 0,  3,  3,  32'hB, 32'hA, D2,  1,  1,  0, 32'hB, 32'hB);
        vecs[9]  = mk(1, 1, 0, 0, 7,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[10] = mk(1, 1, 0, 1, 3,  3,  0,  D0,    D1,    D2,  3,  0,  0, D2,    0);
        vecs[11] = mk(1, 0, 0, 0, 0,  7,  3,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[12] = mk(1, 1, 1, 0, 8,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[13] = mk(1, 0, 0, 1, 0,  8,  0,  D0,    D1,    D2,  0,  0,  1, 0,     0);
        vecs[14] = mk(1, 0, 0, 0, 0,  8,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[15] = mk(1, 1, 1, 0, 8,  0,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[16] = mk(0, 0, 0, 0, 0,  8,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);
        vecs[17] = mk(1, 0, 0, 0, 0,  8,  0,  D0,    D1,    D2,  2,  0,  0, D1,    0);
        vecs[18] = mk(1, 0, 0, 0, 0,  8,  8,  D0,    D1,    D2,  3,  3,  0, D2,    D2);
        vecs[19] = mk(1, 0, 0, 0, 0,  8,  0,  D0,    D1,    D2,  0,  0,  0, 0,     0);

        // Reset with live-looking inputs: an empty scoreboard forwards nothing.
        rst = 1'b1;
        drive(mk(1, 1, 1, 0, 8, 8, 5, D0, D1, D2, 0, 0, 0, 0, 0));
        @(posedge clk);
        #3;
        check("reset sel", 32'(fwd_sel), 32'd0);
        check("reset data", fwd_data[31:0] | fwd_data[63:32], 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply($sformatf("r%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of a load-use stall.
        apply("mr load", mk(1, 1, 1, 0, 8, 0, 0, D0, D1, D2, 0, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 8, 0, D0, D1, D2, 0, 0, 0, 0, 0));
        #2;
        check("mr stall before", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("mr stall during", 32'(stall), 32'd0);
        check("mr sel during", 32'(fwd_sel), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("mr after", mk(1, 0, 0, 0, 0, 8, 8, D0, D1, D2, 0, 0, 0, 0, 0));

`ifdef FWD_STALL_CNT_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("cnt cleared", stall_cnt, 32'd0);
        for (int h = 0; h < 3; h++) begin
            apply($sformatf("cnt ld%0d", h),
                  mk(1, 1, 1, 0, 5'(8 + h), 0, 0, D0, D1, D2, 0, 0, 0, 0, 0));
            apply($sformatf("cnt use%0d", h),
                  mk(1, 0, 0, 0, 0, 5'(8 + h), 0, D0, D1, D2, 0, 0, 1, 0, 0));
            apply($sformatf("cnt retry%0d", h),
                  mk(1, 0, 0, 0, 0, 5'(8 + h), 0, D0, D1, D2, 2, 0, 0, D1, 0));
        end
        check("cnt three", stall_cnt, 32'd3);
        apply("cnt flush", mk(0, 0, 0, 1, 0, 0, 0, D0, D1, D2, 0, 0, 0, 0, 0));
        check("cnt after flush", stall_cnt, 32'd3);
        rst = 1'b1;
        #1;
        check("cnt after rst", stall_cnt, 32'd0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
